// File: rtl/adc_sequencer_if.sv
// ADC command/response bus: single-beat Avalon-ST command with ready, response stream without backpressure.
// The sequencer uses the master modport; the ADC core, or a model standing in for it, uses the slave modport.
interface adc_sequencer_if;
  logic        adc_command_valid;
  logic [4:0]  adc_command_channel;
  logic        adc_command_startofpacket;
  logic        adc_command_endofpacket;
  logic        adc_command_ready;
  logic        adc_response_valid;
  logic [4:0]  adc_response_channel;
  logic [11:0] adc_response_data;

  modport master (
    output adc_command_valid, adc_command_channel,
           adc_command_startofpacket, adc_command_endofpacket,
    input  adc_command_ready,
           adc_response_valid, adc_response_channel, adc_response_data
  );

  modport slave (
    input  adc_command_valid, adc_command_channel,
           adc_command_startofpacket, adc_command_endofpacket,
    output adc_command_ready,
           adc_response_valid, adc_response_channel, adc_response_data
  );
endinterface

// File: rtl/adc_sequencer.sv
// ADC initiator: each sample tick, one command per channel slot, then forward each result (raw and DC-centred signed).
// Latency: sample one cycle after a matching response; backpressure: command held until ready, responses never stalled.
module adc_sequencer #(
  parameter int          NUM_CH     = 2,
  parameter logic [4:0]  CH_A       = 5'd1,
  parameter logic [4:0]  CH_B       = 5'd2,
  parameter int          SAMPLE_DIV = 1000,
  parameter int          TIMEOUT    = 255
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               enable,
  input  logic               clear_flags,
  adc_sequencer_if.master    adc,
  output logic               sample_valid,
  output logic               sample_slot,
  output logic [11:0]        sample_data,
  output logic [15:0]        sample_signed,
  output logic               overrun,
  output logic               timeout,
  output logic               chan_err
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic            slot;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_inc;
  logic [4:0]      cur_ch;
  logic            last_slot;
  logic            rsp_match;
  logic            cmd_valid;
  logic [4:0]      cmd_channel;
  logic            start_seq;
  logic            adv_slot;
  logic            capture;
  logic            set_timeout;
  logic            set_chan_err;

  // Free-running divider; enable only gates whether a tick starts a sequence.
  assign tick = (div_cnt == DW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DW'(1);
  end

  assign cur_ch    = slot ? CH_B : CH_A;
  assign last_slot = (NUM_CH == 1) ? 1'b1 : slot;
  assign rsp_match = adc.adc_response_valid && (adc.adc_response_channel == cur_ch);
  assign tcnt_inc  = tcnt + TW'(1);

  assign adc.adc_command_valid         = cmd_valid;
  assign adc.adc_command_channel       = cmd_channel;
  assign adc.adc_command_startofpacket = cmd_valid;
  assign adc.adc_command_endofpacket   = cmd_valid;

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd_valid    = 1'b0;
    cmd_channel  = 5'd0;
    start_seq    = 1'b0;
    adv_slot     = 1'b0;
    capture      = 1'b0;
    set_timeout  = 1'b0;
    set_chan_err = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) begin
          start_seq = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cmd_valid   = 1'b1;
        cmd_channel = cur_ch;
        if (adc.adc_command_ready)
          state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_match) begin
          capture = 1'b1;
          if (last_slot) begin
            state_nxt = IDLE;
          end else begin
            adv_slot  = 1'b1;
            state_nxt = ISSUE;
          end
        end else begin
          set_chan_err = adc.adc_response_valid;
          // tcnt is 0 in the first wait cycle, so this fires on the TIMEOUT-th wait cycle.
          if (tcnt_inc == TW'(TIMEOUT)) begin
            set_timeout = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      slot          <= 1'b0;
      tcnt          <= '0;
      sample_valid  <= 1'b0;
      sample_slot   <= 1'b0;
      sample_data   <= 12'd0;
      sample_signed <= 16'd0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
      chan_err      <= 1'b0;
    end else begin
      sample_valid <= capture;
      if (capture) begin
        sample_slot   <= slot;
        sample_data   <= adc.adc_response_data;
        sample_signed <= {~adc.adc_response_data[11], adc.adc_response_data[10:0], 4'b0000};
      end
      if (start_seq)
        slot <= 1'b0;
      else if (adv_slot)
        slot <= 1'b1;
      if (state == ISSUE)
        tcnt <= '0;
      else if (state == WAIT_RSP)
        tcnt <= tcnt_inc;
      // Set outranks a coincident clear.
      overrun  <= (tick && (state != IDLE)) || (overrun  && !clear_flags);
      timeout  <= set_timeout               || (timeout  && !clear_flags);
      chan_err <= set_chan_err              || (chan_err && !clear_flags);
    end
  end
endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: 16-cycle ticks, 20-cycle response timeout, channels 1 and 2.
// Inputs driven and outputs sampled on the falling edge; responses are hand-timed per scenario.
module tb_adc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_flags;
  logic        sample_valid;
  logic        sample_slot;
  logic [11:0] sample_data;
  logic [15:0] sample_signed;
  logic        overrun;
  logic        timeout;
  logic        chan_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  adc_sequencer_if bus();

  adc_sequencer #(
    .NUM_CH(2), .CH_A(5'd1), .CH_B(5'd2), .SAMPLE_DIV(16), .TIMEOUT(20)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .enable(enable), .clear_flags(clear_flags),
    .adc(bus),
    .sample_valid(sample_valid), .sample_slot(sample_slot), .sample_data(sample_data),
    .sample_signed(sample_signed), .overrun(overrun), .timeout(timeout), .chan_err(chan_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (bus.adc_command_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic rsp_beat(input logic [4:0] ch, input logic [11:0] d);
    bus.adc_response_valid   = 1'b1;
    bus.adc_response_channel = ch;
    bus.adc_response_data    = d;
    @(negedge clk);
    bus.adc_response_valid   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear_flags = 1'b0;
    bus.adc_command_ready = 1'b1; bus.adc_response_valid = 1'b0;
    bus.adc_response_channel = 5'd0; bus.adc_response_data = 12'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.adc_command_valid, bus.adc_command_channel, bus.adc_command_startofpacket, bus.adc_command_endofpacket} !== 8'h00) begin
      n_bad++; $display("FAIL reset_cmd: got %h want 00", {bus.adc_command_valid, bus.adc_command_channel, bus.adc_command_startofpacket, bus.adc_command_endofpacket}); end
    n_cmp++; if ({sample_valid, sample_slot, sample_data, sample_signed} !== 30'd0) begin
      n_bad++; $display("FAIL reset_sample: got %h want 0", {sample_valid, sample_slot, sample_data, sample_signed}); end
    n_cmp++; if ({overrun, timeout, chan_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {overrun, timeout, chan_err}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    wait_cmd(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_cmd_seen: got %b want 1", ok); end
    n_cmp++; if ({bus.adc_command_channel, bus.adc_command_startofpacket, bus.adc_command_endofpacket} !== {5'd1, 2'b11}) begin
      n_bad++; $display("FAIL basic_cmd0: got ch=%0d sop/eop=%b%b want ch=1 sop/eop=11", bus.adc_command_channel, bus.adc_command_startofpacket, bus.adc_command_endofpacket); end
    @(negedge clk);
    n_cmp++; if (bus.adc_command_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", bus.adc_command_valid); end
    repeat (2) @(negedge clk);
    rsp_beat(5'd1, 12'h800);
    n_cmp++; if ({sample_valid, sample_slot, sample_data, sample_signed} !== {1'b1, 1'b0, 12'h800, 16'h0000}) begin
      n_bad++; $display("FAIL basic_sample0: got v/slot/data/signed=%b/%b/%h/%h want 1/0/800/0000", sample_valid, sample_slot, sample_data, sample_signed); end
    n_cmp++; if ({bus.adc_command_valid, bus.adc_command_channel} !== {1'b1, 5'd2}) begin
      n_bad++; $display("FAIL basic_cmd1: got v=%b ch=%0d want v=1 ch=2", bus.adc_command_valid, bus.adc_command_channel); end
    repeat (3) @(negedge clk);
    rsp_beat(5'd2, 12'hFFF);
    n_cmp++; if ({sample_valid, sample_slot, sample_data, sample_signed} !== {1'b1, 1'b1, 12'hFFF, 16'h7FF0}) begin
      n_bad++; $display("FAIL basic_sample1: got v/slot/data/signed=%b/%b/%h/%h want 1/1/fff/7ff0", sample_valid, sample_slot, sample_data, sample_signed); end
    n_cmp++; if ({overrun, timeout, chan_err} !== 3'b000) begin
      n_bad++; $display("FAIL basic_flags: got %b want 000", {overrun, timeout, chan_err}); end
    @(negedge clk);
    n_cmp++; if ({sample_valid, sample_data, bus.adc_command_valid} !== {1'b0, 12'hFFF, 1'b0}) begin
      n_bad++; $display("FAIL basic_hold: got v=%b data=%h cmd_v=%b want v=0 data=fff cmd_v=0", sample_valid, sample_data, bus.adc_command_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stable_bad;
    bus.adc_command_ready = 1'b0;
    wait_cmd(ok);
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if ({bus.adc_command_valid, bus.adc_command_channel, bus.adc_command_startofpacket, bus.adc_command_endofpacket} !== {1'b1, 5'd1, 2'b11})
        stable_bad++;
    end
    n_cmp++; if (stable_bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", stable_bad); end
    @(negedge clk);
    bus.adc_command_ready = 1'b1;
    n_cmp++; if ({bus.adc_command_valid, bus.adc_command_channel} !== {1'b1, 5'd1}) begin
      n_bad++; $display("FAIL bp_cycle6: got v=%b ch=%0d want v=1 ch=1", bus.adc_command_valid, bus.adc_command_channel); end
    @(negedge clk);
    n_cmp++; if (bus.adc_command_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got %b want 0", bus.adc_command_valid); end
    repeat (2) @(negedge clk);
    rsp_beat(5'd1, 12'h123);
    n_cmp++; if ({sample_valid, sample_slot, sample_data, sample_signed} !== {1'b1, 1'b0, 12'h123, 16'h9230}) begin
      n_bad++; $display("FAIL bp_sample0: got %b/%b/%h/%h want 1/0/123/9230", sample_valid, sample_slot, sample_data, sample_signed); end
    repeat (3) @(negedge clk);
    rsp_beat(5'd2, 12'h7FF);
    n_cmp++; if ({sample_valid, sample_slot, sample_data, sample_signed} !== {1'b1, 1'b1, 12'h7FF, 16'hFFF0}) begin
      n_bad++; $display("FAIL bp_sample1: got %b/%b/%h/%h want 1/1/7ff/fff0", sample_valid, sample_slot, sample_data, sample_signed); end
  endtask

  task automatic test_timeout();
    bit ok;
    bit seen;
    int n;
    wait_cmd(ok);
    @(posedge clk);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (timeout === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (n !== 20) begin n_bad++; $display("FAIL to_latency: got %0d cycles want 20", n); end
    n_cmp++; if ({timeout, overrun, chan_err} !== 3'b110) begin
      n_bad++; $display("FAIL to_flags: got to/ovr/ce=%b want 110", {timeout, overrun, chan_err}); end
    wait_cmd(ok);
    n_cmp++; if ({ok, bus.adc_command_channel} !== {1'b1, 5'd1}) begin
      n_bad++; $display("FAIL to_restart: got seen=%b ch=%0d want seen=1 ch=1", ok, bus.adc_command_channel); end
    @(negedge clk);
    rsp_beat(5'd1, 12'h800);
    @(negedge clk);
    rsp_beat(5'd2, 12'h800);
    n_cmp++; if ({sample_valid, sample_slot} !== 2'b11) begin
      n_bad++; $display("FAIL to_resume: got v/slot=%b%b want 11", sample_valid, sample_slot); end
    pulse_clear();
    n_cmp++; if ({timeout, overrun} !== 2'b00) begin n_bad++; $display("FAIL to_clear: got %b want 00", {timeout, overrun}); end
  endtask

  task automatic test_chan_err();
    bit ok;
    wait_cmd(ok);
    @(negedge clk);
    bus.adc_response_valid = 1'b1; bus.adc_response_channel = 5'd5; bus.adc_response_data = 12'hABC;
    @(negedge clk);
    n_cmp++; if ({sample_valid, chan_err} !== 2'b01) begin
      n_bad++; $display("FAIL ce_drop: got v/ce=%b%b want 01", sample_valid, chan_err); end
    bus.adc_response_channel = 5'd1; bus.adc_response_data = 12'h456;
    @(negedge clk);
    bus.adc_response_valid = 1'b0;
    n_cmp++; if ({sample_valid, sample_slot, sample_data} !== {1'b1, 1'b0, 12'h456}) begin
      n_bad++; $display("FAIL ce_sample: got %b/%b/%h want 1/0/456", sample_valid, sample_slot, sample_data); end
    @(negedge clk);
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL ce_single: got %b want 0", sample_valid); end
    @(negedge clk);
    rsp_beat(5'd2, 12'h000);
    n_cmp++; if ({sample_valid, sample_slot, sample_data, sample_signed} !== {1'b1, 1'b1, 12'h000, 16'h8000}) begin
      n_bad++; $display("FAIL ce_min: got %b/%b/%h/%h want 1/1/000/8000", sample_valid, sample_slot, sample_data, sample_signed); end
    pulse_clear();
    n_cmp++; if (chan_err !== 1'b0) begin n_bad++; $display("FAIL ce_clear: got %b want 0", chan_err); end
  endtask

  task automatic test_overrun();
    bit ok;
    bit busy;
    wait_cmd(ok);
    busy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (bus.adc_command_valid !== 1'b0) busy = 1'b1;
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovr_no_restart: got cmd during wait=%b want 0", busy); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    @(negedge clk);
    rsp_beat(5'd1, 12'h800);
    n_cmp++; if ({sample_valid, sample_slot, sample_data} !== {1'b1, 1'b0, 12'h800}) begin
      n_bad++; $display("FAIL ovr_sample0: got %b/%b/%h want 1/0/800", sample_valid, sample_slot, sample_data); end
    @(negedge clk);
    rsp_beat(5'd2, 12'hFFF);
    n_cmp++; if ({sample_valid, sample_slot, timeout} !== 3'b110) begin
      n_bad++; $display("FAIL ovr_sample1: got v/slot/to=%b want 110", {sample_valid, sample_slot, timeout}); end
    pulse_clear();
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_cmd(ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.adc_command_valid, bus.adc_command_channel, sample_valid, sample_slot, sample_data, sample_signed} !== 36'd0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got cmd_v=%b slot=%b data=%h signed=%h want all 0", bus.adc_command_valid, sample_slot, sample_data, sample_signed); end
    n_cmp++; if ({overrun, timeout, chan_err} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b want 000", {overrun, timeout, chan_err}); end
    rst = 1'b0;
    rsp_beat(5'd1, 12'h555);
    n_cmp++; if ({sample_valid, sample_data} !== 13'd0) begin
      n_bad++; $display("FAIL rst_late_rsp: got v=%b data=%h want 0/000", sample_valid, sample_data); end
    @(negedge clk);
    n_cmp++; if ({sample_valid, chan_err} !== 2'b00) begin
      n_bad++; $display("FAIL rst_late_quiet: got v/ce=%b%b want 00", sample_valid, chan_err); end
  endtask

  task automatic test_disable();
    bit ok;
    bit busy;
    wait_cmd(ok);
    enable = 1'b0;
    @(negedge clk);
    rsp_beat(5'd1, 12'h001);
    @(negedge clk);
    rsp_beat(5'd2, 12'h002);
    n_cmp++; if ({sample_valid, sample_slot, sample_data} !== {1'b1, 1'b1, 12'h002}) begin
      n_bad++; $display("FAIL dis_complete: got %b/%b/%h want 1/1/002", sample_valid, sample_slot, sample_data); end
    busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.adc_command_valid !== 1'b0) busy = 1'b1;
    end
    n_cmp++; if ({busy, overrun} !== 2'b00) begin
      n_bad++; $display("FAIL dis_idle: got cmd/ovr=%b%b want 00", busy, overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_chan_err();
    test_overrun();
    test_reset_mid();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
